// File: rtl/sdpmem_fwd_if.sv
// Bus bundle for sdpmem_fwd: port-A write channel, port-B read channel and
// the registered read result.
//   master : drives wea/bea/addra/dia (write) and reb/addrb (read), sees dob/dob_valid
//   slave  : the memory; samples the request signals, drives dob/dob_valid
interface sdpmem_fwd_if #(
   parameter int unsigned DEPTH = 6,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BYTE  = 8
);
   localparam int unsigned NB = WIDTH / BYTE;

   logic             wea;
   logic [NB-1:0]    bea;
   logic [DEPTH-1:0] addra;
   logic [WIDTH-1:0] dia;
   logic             reb;
   logic [DEPTH-1:0] addrb;
   logic [WIDTH-1:0] dob;
   logic             dob_valid;

   modport master (
      output wea, bea, addra, dia, reb, addrb,
      input  dob, dob_valid
   );

   modport slave (
      input  wea, bea, addra, dia, reb, addrb,
      output dob, dob_valid
   );
endinterface

// File: rtl/sdpmem_fwd.sv
// Simple dual-port RAM: port A writes with per-byte enables, port B reads
// through a registered path of 1 (OREG=0) or 2 (OREG=1) cycles. FWD selects
// whether a same-address read-during-write returns the merged new word (1)
// or the old word (0).
//   clk  : single rising-edge clock
//   srst : synchronous active-high reset (clears read pipeline, not the RAM)
//   bus  : sdpmem_fwd_if.slave (write channel, read channel, dob/dob_valid)
module sdpmem_fwd #(
   parameter int unsigned DEPTH = 6,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BYTE  = 8,
   parameter int unsigned OREG  = 0,
   parameter int unsigned FWD   = 1
) (
   input  logic         clk,
   input  logic         srst,
   sdpmem_fwd_if.slave  bus
);
   localparam int unsigned NB    = WIDTH / BYTE;
   localparam int unsigned WORDS = 2 ** DEPTH;

   logic [WIDTH-1:0] mem [WORDS];
   logic [WIDTH-1:0] rd_old;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] q1;
   logic             v1;

   // Storage array with byte-lane write enables; no reset so it maps to RAM.
   always_ff @(posedge clk) begin
      if (!srst && bus.wea) begin
         for (int i = 0; i < int'(NB); i++) begin
            if (bus.bea[i]) begin
               mem[bus.addra][i*BYTE +: BYTE] <= bus.dia[i*BYTE +: BYTE];
            end
         end
      end
   end

   // Array read port returns pre-write contents; forwarding is merged after it.
   assign rd_old = mem[bus.addrb];

   generate
      if (FWD != 0) begin : g_fwd
         logic hit;
         assign hit = bus.wea && (bus.addra == bus.addrb);

         // Same-address collision: enabled lanes come from the write data.
         always_comb begin
            rd_word = rd_old;
            if (hit) begin
               for (int i = 0; i < int'(NB); i++) begin
                  if (bus.bea[i]) begin
                     rd_word[i*BYTE +: BYTE] = bus.dia[i*BYTE +: BYTE];
                  end
               end
            end
         end
      end else begin : g_nofwd
         assign rd_word = rd_old;
      end
   endgenerate

   // Stage 1: capture on accepted read, otherwise hold data and drop valid.
   always_ff @(posedge clk) begin
      if (srst) begin
         q1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= bus.reb;
         if (bus.reb) begin
            q1 <= rd_word;
         end
      end
   end

   generate
      if (OREG != 0) begin : g_oreg
         logic [WIDTH-1:0] q2;
         logic             v2;

         // Stage 2: data moves only with a valid stage-1 result so dob holds.
         always_ff @(posedge clk) begin
            if (srst) begin
               q2 <= '0;
               v2 <= 1'b0;
            end else begin
               v2 <= v1;
               if (v1) begin
                  q2 <= q1;
               end
            end
         end

         assign bus.dob       = q2;
         assign bus.dob_valid = v2;
      end else begin : g_noreg
         assign bus.dob       = q1;
         assign bus.dob_valid = v1;
      end
   endgenerate
endmodule

// File: tb/tb_sdpmem_fwd.sv
// Self-checking bench for sdpmem_fwd. Two builds run side by side on the same
// stimulus: dut_a (OREG=0, FWD=1) and dut_b (OREG=1, FWD=0). A word-level
// reference model tracks RAM contents and the expected read results.
`timescale 1ns/1ps
module tb_sdpmem_fwd;
   logic        clk;
   logic        srst;
   logic        wea;
   logic [3:0]  bea;
   logic [5:0]  addra;
   logic [31:0] dia;
   logic        reb;
   logic [5:0]  addrb;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] ref_mem [64];
   logic [31:0] exp_dob_a, exp_dob_b, pend_d;
   logic        exp_v_a, exp_v_b, pend_v;

   sdpmem_fwd_if bus_a ();
   sdpmem_fwd_if bus_b ();

   assign bus_a.wea = wea;   assign bus_b.wea = wea;
   assign bus_a.bea = bea;   assign bus_b.bea = bea;
   assign bus_a.addra = addra; assign bus_b.addra = addra;
   assign bus_a.dia = dia;   assign bus_b.dia = dia;
   assign bus_a.reb = reb;   assign bus_b.reb = reb;
   assign bus_a.addrb = addrb; assign bus_b.addrb = addrb;

   sdpmem_fwd #(.DEPTH(6), .WIDTH(32), .BYTE(8), .OREG(0), .FWD(1)) dut_a (
      .clk(clk), .srst(srst), .bus(bus_a));
   sdpmem_fwd #(.DEPTH(6), .WIDTH(32), .BYTE(8), .OREG(1), .FWD(0)) dut_b (
      .clk(clk), .srst(srst), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   // One clock edge: apply the request to the model, then return at the falling edge.
   task automatic tick();
      logic [31:0] old, fwd;
      @(posedge clk);
      if (srst) begin
         exp_v_a = 1'b0; exp_dob_a = '0;
         exp_v_b = 1'b0; exp_dob_b = '0;
         pend_v  = 1'b0; pend_d    = '0;
      end else begin
         old = ref_mem[addrb];
         fwd = (wea && addra == addrb) ? merge(old, dia, bea) : old;
         exp_v_a = reb;
         if (reb) exp_dob_a = fwd;
         // 2-cycle build: result issued last edge emerges now, this one is pending
         exp_v_b = pend_v;
         if (pend_v) exp_dob_b = pend_d;
         pend_v = reb;
         if (reb) pend_d = old;
         if (wea) ref_mem[addra] = merge(ref_mem[addra], dia, bea);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      srst = 1'b0; wea = 1'b0; reb = 1'b0; bea = '0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      wea = 1'b1; addra = a; dia = d; bea = be;
   endtask

   task automatic test_reset();
      srst = 1'b1; wea = 1'b0; reb = 1'b0; bea = '0;
      addra = '0; addrb = '0; dia = '0;
      tick(); tick();
      n_cmp++;
      if (bus_a.dob !== 32'h0 || bus_a.dob_valid !== 1'b0 ||
          bus_b.dob !== 32'h0 || bus_b.dob_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset: a=%h/%b b=%h/%b required 0/0", bus_a.dob, bus_a.dob_valid,
                  bus_b.dob, bus_b.dob_valid);
      end
      idle();
   endtask

   task automatic test_fill_random();
      for (int a = 0; a < 64; a++) begin
         wr(6'(a), $urandom, 4'hF);
         tick();
      end
      idle();
   endtask

   task automatic test_basic();
      wr(6'd5, 32'hDEADBEEF, 4'hF); tick(); idle();
      reb = 1'b1; addrb = 6'd5; tick(); idle();
      n_cmp++;
      if (bus_a.dob !== 32'hDEADBEEF || bus_a.dob_valid !== 1'b1 || bus_b.dob_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_lat1: a=%h/%b b_v=%b required DEADBEEF/1 b_v=0",
                  bus_a.dob, bus_a.dob_valid, bus_b.dob_valid);
      end
      tick();
      n_cmp++;
      if (bus_b.dob !== 32'hDEADBEEF || bus_b.dob_valid !== 1'b1 || bus_a.dob_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_lat2: b=%h/%b a_v=%b required DEADBEEF/1 a_v=0",
                  bus_b.dob, bus_b.dob_valid, bus_a.dob_valid);
      end
      tick();
      n_cmp++;
      if (bus_b.dob_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_single_pulse: b_v=%b required 0", bus_b.dob_valid);
      end
   endtask

   task automatic test_byte_en();
      wr(6'd3, 32'h11223344, 4'hF); tick();
      wr(6'd3, 32'hAABBCCDD, 4'h5); tick(); idle();
      wr(6'd3, 32'h99999999, 4'h0); tick(); idle();
      reb = 1'b1; addrb = 6'd3; tick(); idle();
      n_cmp++;
      if (bus_a.dob !== 32'h11BB33DD || bus_a.dob_valid !== 1'b1) begin
         n_err++;
         $display("FAIL byte_en_a: got %h/%b required 11BB33DD/1", bus_a.dob, bus_a.dob_valid);
      end
      tick();
      n_cmp++;
      if (bus_b.dob !== 32'h11BB33DD || bus_b.dob_valid !== 1'b1) begin
         n_err++;
         $display("FAIL byte_en_b: got %h/%b required 11BB33DD/1", bus_b.dob, bus_b.dob_valid);
      end
   endtask

   task automatic test_rdw();
      wr(6'd7, 32'h0, 4'hF); tick(); idle();
      wr(6'd7, 32'hCAFEF00D, 4'h3); reb = 1'b1; addrb = 6'd7; tick();
      wea = 1'b0; bea = '0;
      n_cmp++;
      if (bus_a.dob !== 32'h0000F00D || bus_a.dob_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rdw_fwd: got %h/%b required 0000F00D/1", bus_a.dob, bus_a.dob_valid);
      end
      tick(); idle();
      n_cmp++;
      if (bus_b.dob !== 32'h00000000 || bus_b.dob_valid !== 1'b1 ||
          bus_a.dob !== 32'h0000F00D || bus_a.dob_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rdw_old: b=%h/%b a=%h/%b required b 00000000/1 a 0000F00D/1",
                  bus_b.dob, bus_b.dob_valid, bus_a.dob, bus_a.dob_valid);
      end
      tick();
      n_cmp++;
      if (bus_b.dob !== 32'h0000F00D || bus_b.dob_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rdw_after: b=%h/%b required 0000F00D/1", bus_b.dob, bus_b.dob_valid);
      end
   endtask

   task automatic test_stream();
      int pulses;
      for (int a = 0; a < 64; a++) begin
         wr(6'(a), 32'(a), 4'hF); tick();
      end
      idle();
      pulses = 0;
      for (int k = 0; k < 66; k++) begin
         if (k < 64) begin
            reb = 1'b1; addrb = 6'(k);
            wr(6'(k + 1), 32'hFFFFFFFF, 4'hF);
         end else idle();
         tick();
         if (bus_b.dob_valid === 1'b1) pulses++;
         n_cmp++;
         if (bus_a.dob !== exp_dob_a || bus_a.dob_valid !== exp_v_a ||
             bus_b.dob !== exp_dob_b || bus_b.dob_valid !== exp_v_b) begin
            n_err++;
            $display("FAIL stream k=%0d: a=%h/%b b=%h/%b required a=%h/%b b=%h/%b", k,
                     bus_a.dob, bus_a.dob_valid, bus_b.dob, bus_b.dob_valid,
                     exp_dob_a, exp_v_a, exp_dob_b, exp_v_b);
         end
      end
      idle();
      n_cmp++;
      if (pulses != 64) begin
         n_err++;
         $display("FAIL stream_count: got %0d pulses required 64", pulses);
      end
   endtask

   task automatic test_reset_mid();
      wr(6'd20, 32'h5A5A1234, 4'hF); tick(); idle();
      reb = 1'b1; addrb = 6'd20; tick();
      srst = 1'b1; reb = 1'b1; wr(6'd20, 32'hFFFF0000, 4'hF); tick(); idle();
      n_cmp++;
      if (bus_a.dob !== 32'h0 || bus_a.dob_valid !== 1'b0 ||
          bus_b.dob !== 32'h0 || bus_b.dob_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: a=%h/%b b=%h/%b required 0/0",
                  bus_a.dob, bus_a.dob_valid, bus_b.dob, bus_b.dob_valid);
      end
      tick(); tick();
      n_cmp++;
      if (bus_b.dob !== 32'h0 || bus_b.dob_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_discard: b=%h/%b required 0/0", bus_b.dob, bus_b.dob_valid);
      end
      reb = 1'b1; addrb = 6'd20; tick(); idle(); tick();
      n_cmp++;
      if (bus_b.dob !== 32'h5A5A1234 || bus_b.dob_valid !== 1'b1 || bus_a.dob !== 32'h5A5A1234) begin
         n_err++;
         $display("FAIL reset_keep_ram: b=%h/%b a=%h required 5A5A1234/1 a 5A5A1234",
                  bus_b.dob, bus_b.dob_valid, bus_a.dob);
      end
   endtask

   task automatic test_idle_hold();
      wr(6'd9, 32'h12345678, 4'hF); tick(); idle();
      reb = 1'b1; addrb = 6'd9; tick(); idle(); tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if (bus_a.dob !== 32'h12345678 || bus_a.dob_valid !== 1'b0 ||
             bus_b.dob !== 32'h12345678 || bus_b.dob_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold i=%0d: a=%h/%b b=%h/%b required 12345678/0", i,
                     bus_a.dob, bus_a.dob_valid, bus_b.dob, bus_b.dob_valid);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         srst  = ($urandom_range(0, 31) == 0);
         wea   = 1'($urandom);
         bea   = 4'($urandom);
         addra = 6'($urandom_range(0, 7));
         dia   = $urandom;
         reb   = 1'($urandom);
         addrb = 6'($urandom_range(0, 7));
         tick();
         n_cmp++;
         if (bus_a.dob !== exp_dob_a || bus_a.dob_valid !== exp_v_a ||
             bus_b.dob !== exp_dob_b || bus_b.dob_valid !== exp_v_b) begin
            n_err++;
            $display("FAIL random c=%0d: a=%h/%b b=%h/%b required a=%h/%b b=%h/%b", c,
                     bus_a.dob, bus_a.dob_valid, bus_b.dob, bus_b.dob_valid,
                     exp_dob_a, exp_v_a, exp_dob_b, exp_v_b);
         end
      end
      idle();
   endtask

   initial begin
      exp_dob_a = '0; exp_dob_b = '0; pend_d = '0;
      exp_v_a = 1'b0; exp_v_b = 1'b0; pend_v = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      test_reset();
      test_fill_random();
      test_basic();
      test_byte_en();
      test_rdw();
      test_stream();
      test_reset_mid();
      test_idle_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sdpmem_fwd.md
# sdpmem_fwd

Synchronous simple dual-port RAM with per-byte write enables, a selectable read latency of 1 or 2 cycles and configurable read-during-write behaviour. It succeeds the asynchronous-read dual-port memory. It serves as the registered storage primitive for FIFOs, register files and line buffers that need a clean registered read path and a `dob_valid` qualifier. Port A writes and port B reads, both on one clock.

## Interface
- `DEPTH`, 6: address width in bits; the memory holds 2**DEPTH words.
- `WIDTH`, 32: data width in bits; must be a multiple of `BYTE`.
- `BYTE`, 8: byte-lane width in bits; the lane count is NB = WIDTH/BYTE.
- `OREG`, 0: 0 gives a 1-cycle read latency; 1 adds an output register for a 2-cycle latency.
- `FWD`, 1: 1 makes a same-address read-during-write return the new (merged) data; 0 makes it return the old data.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `srst`  in  1  synchronous, active-high reset.
- `wea`  in  1  write strobe for port A.
- `bea`  in  NB  byte-lane enables; lane i covers dia[i*BYTE +: BYTE].
- `addra`  in  DEPTH  write address.
- `dia`  in  WIDTH  write data.
- `reb`  in  1  read strobe for port B.
- `addrb`  in  DEPTH  read address.
- `dob`  out  WIDTH  read data.
- `dob_valid`  out  1  high for exactly one cycle per accepted read, aligned with `dob`.

## Operation
- Write: on an edge with `wea`=1 and `srst`=0, every lane i with `bea[i]`=1 takes its bytes from `dia`. Lanes with `bea[i]`=0 keep their contents.
- `wea`=1 with `bea`=0 changes nothing.
- Read: on an edge with `reb`=1 and `srst`=0, the word at `addrb` is captured into the stage-1 register `q1`, and `v1` is set to 1.
- With `reb`=0, `q1` holds its value and `v1` is set to 0.
- Read-during-write (`wea`=`reb`=1, `addra`=`addrb`, same edge):
  - `FWD`=1: `q1` receives, per lane, `dia` where `bea` is set and the old RAM byte otherwise.
  - `FWD`=0: `q1` receives the old word for every lane.
  - The RAM update happens in both modes.
- Different addresses on a write/read edge: the read returns the RAM contents, with no interaction with the write.
- A read one or more cycles after a write to the same address always returns the written data.
- `OREG`=0: `dob` = `q1` and `dob_valid` = `v1`.
- `OREG`=1:
  - `q2` and `v2` register `q1` and `v1` every cycle; `q2` loads only when `v1`=1, otherwise it holds.
  - `dob` = `q2` and `dob_valid` = `v2`.
  - A write landing between stage 1 and stage 2 does not alter data already captured in `q1`.
- Back-to-back reads on consecutive cycles are accepted at full rate, one result per cycle, in issue order.
- Reset:
  - While `srst`=1, writes and reads are ignored.
  - `q1`, `q2` and `dob` go to 0; `v1`, `v2` and `dob_valid` go to 0.
  - RAM contents are not cleared and keep their pre-reset values.
- Reset mid-operation: reads in flight when `srst` rises are discarded, and no `dob_valid` pulse is produced for them. A write on the same edge as `srst`=1 is dropped.
- No illegal states exist. Addresses wrap naturally by DEPTH bits; out-of-range addresses are impossible.
- RAM contents are undefined until written. No read-before-write check is performed.
- The storage array must infer as block or distributed RAM with byte-write enables. The forwarding merge must sit outside the array.

## Timing
- Read latency, from the `reb` edge to `dob_valid`=1:
  - `OREG`=0: 1 cycle, so a read issued at edge t is valid after edge t.
  - `OREG`=1: 2 cycles, valid after edge t+1.
- Write latency: 1 cycle. The data is committed at edge t and visible to a read issued at edge t+1.
- Throughput: one write and one read per cycle, simultaneously.
- `dob` is stable between valid pulses; it holds the last read data until the next valid read.
- Reset values: `dob`=0 and `dob_valid`=0 from the first edge with `srst`=1.
- First read acceptance: the first edge with `srst`=0.

## Test plan
- Basic R/W, `OREG`=0:
  - Stimulus: write 0xDEADBEEF to address 5 with `bea`=0xF; next cycle read address 5.
  - Response: `dob`=0xDEADBEEF with `dob_valid`=1 exactly 1 cycle after `reb`.
  - Repeat with `OREG`=1: `dob_valid` follows 2 cycles after `reb`.
- Byte enables:
  - Stimulus: address 3 holds 0x11223344; write 0xAABBCCDD with `bea`=0x5.
  - Response: a read of address 3 returns 0x11BB33DD.
- Read-during-write:
  - Stimulus: address 7 holds 0x00000000; on the same edge, write 0xCAFEF00D with `bea`=0x3 and read address 7.
  - Response: `FWD`=1 returns 0x0000F00D, `FWD`=0 returns 0x00000000. A subsequent read returns 0x0000F00D in both builds.
- Streaming with `OREG`=1:
  - Stimulus: fill addresses 0..63 with value = address; read 0..63 on back-to-back cycles while concurrently rewriting address k+1 with 0xFFFFFFFF.
  - Response: 64 consecutive valid pulses in order, and each `dob` equals the value present at its read edge.
- Reset mid-operation:
  - Stimulus: issue reads at edges t and t+1 with `OREG`=1; assert `srst` at edge t+1.
  - Response: no `dob_valid` pulse and `dob`=0. After `srst` falls, a read returns the pre-reset RAM contents.
  - A write presented with `srst`=1 is verified as not committed.
- Idle hold: after a valid read of 0x12345678, holding `reb`=0 for 10 cycles keeps `dob`=0x12345678 with `dob_valid`=0.
